// File: rtl/alu_seq_if.sv
// Request/response bundle for the multi-cycle ALU.
// master = core side, slave = ALU side.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] rd_i;
  logic [WIDTH-1:0] rs_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             busy_o;

  modport master (
    output valid_i, op_i, rd_i, rs_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, rd_i, rs_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, busy_o
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: single-cycle ops plus
// iterative shift-add multiply and restoring divide.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     n_reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;

  logic ready;
  logic accept;
  logic iter_op;

  always_comb begin
    ready   = (state == IDLE) |
              ((state == DONE) & bus.ready_i);
    accept  = bus.valid_i & ready;
    iter_op = (bus.op_i >= 4'd11) &&
              (bus.op_i <= 4'd14);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) state_n = iter_op ? BUSY : DONE;
      end
      BUSY: begin
        if (cnt_q == '0) state_n = DONE;
      end
      DONE: begin
        if (accept)           state_n = iter_op ? BUSY : DONE;
        else if (bus.ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rol2;
  logic [WIDTH-1:0]   alu;

  always_comb begin
    sh   = bus.rs_i[SHW-1:0];
    rol2 = {bus.rd_i, bus.rd_i} << sh;
    alu  = '0;
    case (bus.op_i)
      4'd0:  alu = bus.rd_i + bus.rs_i;
      4'd1:  alu = bus.rd_i - bus.rs_i;
      4'd2:  alu = bus.rd_i << sh;
      4'd3:  alu = WIDTH'($signed(bus.rd_i) >>> sh);
      4'd4:  alu = bus.rd_i >> sh;
      4'd5:  alu = bus.rd_i & bus.rs_i;
      4'd6:  alu = bus.rd_i | bus.rs_i;
      4'd7:  alu = ~(bus.rd_i | bus.rs_i);
      4'd8:  alu = {{(WIDTH-1){1'b0}},
                    $signed(bus.rd_i) < $signed(bus.rs_i)};
      4'd9:  alu = {{(WIDTH-1){1'b0}},
                    bus.rd_i < bus.rs_i};
      4'd10: alu = rol2[2*WIDTH-1:WIDTH];
      default: alu = '0;
    endcase
  end

  // hi:lo is the product (mul) or remainder:quotient (div)
  logic [WIDTH:0]   mul_s;
  logic [WIDTH:0]   div_t;
  logic [WIDTH:0]   div_d;
  logic             is_div;
  logic             take_lo;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] fin;

  always_comb begin
    is_div  = (op_q == 4'd13) || (op_q == 4'd14);
    take_lo = (op_q == 4'd11) || (op_q == 4'd13);
    mul_s   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q})
                      : {1'b0, hi_q};
    div_t   = {hi_q, lo_q[WIDTH-1]};
    div_d   = div_t - {1'b0, b_q};
    if (is_div) begin
      hi_n = div_d[WIDTH] ? div_t[WIDTH-1:0]
                          : div_d[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ~div_d[WIDTH]};
    end else begin
      hi_n = mul_s[WIDTH:1];
      lo_n = {mul_s[0], lo_q[WIDTH-1:1]};
    end
    fin = take_lo ? lo_n : hi_n;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q <= bus.op_i;
      if (iter_op) begin
        hi_q  <= '0;
        lo_q  <= bus.rd_i;
        b_q   <= bus.rs_i;
        cnt_q <= SHW'(WIDTH-1);
      end else begin
        result_q <= alu;
      end
    end else if (state == BUSY) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - SHW'(1);
      if (cnt_q == '0) result_q <= fin;
    end
  end

  assign bus.ready_o  = ready;
  assign bus.valid_o  = (state == DONE);
  assign bus.busy_o   = (state == BUSY);
  assign bus.result_o = result_q;
  assign bus.zero_o   = (result_q == '0);
endmodule
